// File: rtl/ramp_adc_pkg.sv
// Shared state encoding and averaging constants for the single-slope ramp ADC sequencer.
package ramp_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISCHARGE = 3'd1,
    ST_ARM       = 3'd2,
    ST_RAMP      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Averaging mode sums 2**AVG_SHIFT ramps and divides by shifting.
  localparam int unsigned AVG_SHIFT = 2;
  localparam int unsigned AVG_RUNS  = 1 << AVG_SHIFT;

  // Phase timer must reach both the discharge hold and the sync-flush length.
  function automatic int unsigned tmr_width(input int unsigned discharge_cycles,
                                            input int unsigned sync_stages);
    int unsigned span;
    span = (discharge_cycles > sync_stages + 1) ? discharge_cycles : sync_stages + 1;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/ramp_adc_cmp_sync.sv
// Multi-flop synchronizer bringing the raw LVDS comparator output into the clk domain.
module ramp_adc_cmp_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ramp_adc_sequencer.sv
// Single-slope conversion sequencer: hold ramp discharged, release, count clocks until trip.
// Define RAMP_ADC_AVG4_EN to run four ramps per request and report their truncated mean.
module ramp_adc_sequencer
  import ramp_adc_pkg::*;
#(
  parameter int unsigned CNT_W            = 12,
  parameter int unsigned DISCHARGE_CYCLES = 64,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic             discharge_o,
  output logic             ramp_en_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] data_o,
  output logic             overflow_o
);

  localparam int unsigned      TMR_W   = tmr_width(DISCHARGE_CYCLES, SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic cmp_s;

  ramp_adc_cmp_sync #(
    .STAGES (SYNC_STAGES)
  ) u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cmp_i),
    .q_o   (cmp_s)
  );

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             discharge_q, discharge_d;
  logic             ramp_en_q, ramp_en_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  // One ramp's outcome, raised in the cycle the ramp (or the arm check) finishes.
  logic             seq_end;
  logic [CNT_W-1:0] seq_data;
  logic             seq_ovf;

`ifdef RAMP_ADC_AVG4_EN
  logic [CNT_W+1:0]     acc_q, acc_d;
  logic [CNT_W+1:0]     acc_sum;
  logic [AVG_SHIFT-1:0] run_q, run_d;
  logic                 ovf_acc_q, ovf_acc_d;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    seq_end  = 1'b0;
    seq_data = '0;
    seq_ovf  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DISCHARGE;
          tmr_d   = '0;
        end
      end

      ST_DISCHARGE: begin
        if (tmr_q == TMR_W'(DISCHARGE_CYCLES - 1)) begin
          state_d = ST_ARM;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      // Ramp held flat while the synchronizer flushes stale comparator history.
      ST_ARM: begin
        if (tmr_q == TMR_W'(SYNC_STAGES)) begin
          tmr_d = '0;
          if (cmp_s) begin
            seq_end = 1'b1;
          end else begin
            state_d = ST_RAMP;
            cnt_d   = '0;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      // A trip on the full-scale count is a valid reading, so it is tested first.
      ST_RAMP: begin
        if (cmp_s) begin
          seq_end  = 1'b1;
          seq_data = cnt_q;
        end else if (cnt_q == CNT_MAX) begin
          seq_end  = 1'b1;
          seq_data = CNT_MAX;
          seq_ovf  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef RAMP_ADC_AVG4_EN
    acc_d     = acc_q;
    run_d     = run_q;
    ovf_acc_d = ovf_acc_q;
    acc_sum   = acc_q + {2'b00, seq_data};

    if (state_q == ST_IDLE && start_i) begin
      acc_d     = '0;
      run_d     = '0;
      ovf_acc_d = 1'b0;
    end

    if (seq_end) begin
      if (run_q == AVG_SHIFT'(AVG_RUNS - 1)) begin
        state_d = ST_DONE;
        data_d  = CNT_W'(acc_sum >> AVG_SHIFT);
        ovf_d   = ovf_acc_q | seq_ovf;
      end else begin
        state_d   = ST_DISCHARGE;
        acc_d     = acc_sum;
        run_d     = run_q + AVG_SHIFT'(1);
        ovf_acc_d = ovf_acc_q | seq_ovf;
      end
    end
`else
    if (seq_end) begin
      state_d = ST_DONE;
      data_d  = seq_data;
      ovf_d   = seq_ovf;
    end
`endif

    // Outputs are decoded from the next state so they are flops aligned with state_q.
    discharge_d = !(state_d inside {ST_ARM, ST_RAMP});
    ramp_en_d   = (state_d == ST_RAMP);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      discharge_q <= 1'b1;
      ramp_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      discharge_q <= discharge_d;
      ramp_en_q   <= ramp_en_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

`ifdef RAMP_ADC_AVG4_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      run_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      run_q     <= run_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end
`endif

  assign discharge_o = discharge_q;
  assign ramp_en_o   = ramp_en_q;
  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign overflow_o  = ovf_q;

endmodule
